uart_rx_deserializer: RTL
=========================

# uart_rx_deserializer

Asynchronous serial receiver that converts an 8N1 UART line into parallel bytes using the 16x oversampling tick from the baud rate generator. It sits between the FPGA RX pin and the byte-consuming logic, and is the receive-side counterpart to the baud tick source. It samples each bit at mid-bit, rejects start-bit glitches, and flags framing errors.

## Interface
- `DATA_BITS`, 8, number of data bits per frame; LSB first.
- `OVERSAMPLE`, 16, oversample ticks per bit period; must be even and ≥ 8.
- `clk`  input  1  system clock, 50 MHz.
- `reset_n`  input  1  reset; asynchronous, active-low.
- `i_Rx_ClkTick`  input  1  oversample tick from the baud generator. It is a square wave toggling at 2×OVERSAMPLE×baud. Each rising edge is one oversample period.
- `i_Rx_Serial`  input  1  raw RX line; idle high; asynchronous to `clk`.
- `o_Rx_Data`  output  DATA_BITS  last received byte; held until the next frame completes.
- `o_Rx_Valid`  output  1  one-`clk` pulse when `o_Rx_Data` updates with a good frame.
- `o_Rx_FrameErr`  output  1  one-`clk` pulse when the stop bit is sampled low.
- `o_Rx_ParityErr`  output  1  one-`clk` pulse on parity mismatch; constant 0 when parity is compiled out.
- `o_Rx_Busy`  output  1  high in every state except IDLE.

## Operation
- **Input synchronizer:** `i_Rx_Serial` passes through a 2-FF synchronizer. The flops reset to 1.
- **Tick edge detector:** `i_Rx_ClkTick` is registered, and `s_tick` = current & ~previous (a rising edge). All counters advance only on `s_tick`. `clk` cycles without `s_tick` hold state.
- **Counters:** the sample counter is `$clog2(OVERSAMPLE)` bits; the bit index is `$clog2(DATA_BITS)` bits. No wrap-around is used; both counters are cleared explicitly on every state entry.
- **IDLE:** on `s_tick` with the synchronized line = 0, go to START and clear the sample counter.
- **START:** on `s_tick`, increment the counter. At count OVERSAMPLE/2−1 (mid-bit):
  - line = 0: go to DATA, clear counter and bit index.
  - line = 1: glitch; return to IDLE with no output pulse.
- **DATA:** on `s_tick`, increment the counter. At count OVERSAMPLE−1, shift the line into the shift register MSB, clear the counter, and increment the bit index. After bit DATA_BITS−1, go to PARITY (if enabled) or STOP.
- **PARITY** (only when the macro is defined): sample at count OVERSAMPLE−1 and compare against the even parity of the shifted data. Store the mismatch flag, then go to STOP.
- **STOP:** sample at count OVERSAMPLE−1.
  - line = 1: load `o_Rx_Data` from the shift register. Pulse `o_Rx_Valid`, or pulse `o_Rx_ParityErr` instead if the flag is set. Go to IDLE.
  - line = 0: pulse `o_Rx_FrameErr`, leave `o_Rx_Data` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until the synchronized line is 1 on an `s_tick`, then go to IDLE. This state handles break conditions and a stuck-low line.
- **Reset values** (any state, asynchronous): state = IDLE, all counters 0, shift register 0, `o_Rx_Data` = 0, all pulse outputs 0, `o_Rx_Busy` = 0.
- **Reset mid-frame:** the partial frame is discarded and no pulse is produced.

## Timing
- Input latency: 2 `clk` from a line transition to the synchronized line. The tick edge is recognized 1 `clk` after the rising edge of `i_Rx_ClkTick`.
- Output pulse timing:
  - `o_Rx_Valid`, `o_Rx_FrameErr` and `o_Rx_ParityErr` are registered and high for exactly 1 `clk`.
  - The pulse is asserted in the `clk` after the `s_tick` that samples the stop bit.
  - At most one of the three pulses fires per frame.
- Frame-to-frame timing:
  - A falling edge detected on the first `s_tick` after the return to IDLE starts the next frame.
  - Back-to-back frames with a single stop bit are supported.
- Output hold: `o_Rx_Data` is stable between valid pulses. There is no ready/backpressure; the consumer must capture the byte on the pulse.
- Sampling point: mid-bit, ±1 oversample tick of phase uncertainty.
- Clock tolerance: baud error of ±3% between transmitter and tick is tolerated.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is start, DATA_BITS data bits, one even-parity bit, stop.
  - The PARITY state exists.
  - On mismatch, `o_Rx_ParityErr` pulses and `o_Rx_Valid` is suppressed; `o_Rx_Data` is still loaded.
- Macro undefined:
  - The frame is 8N1, and the PARITY state and its logic are absent.
  - `o_Rx_ParityErr` is tied to 0.

## Test plan
- **Good frame:** send 0xA5 at 9600 baud with the tick from a 50 MHz generator. Expect one `o_Rx_Valid` pulse with `o_Rx_Data` = 0xA5, and no error pulse.
- **Start glitch:** drive the line low for 3 oversample ticks during idle. Expect a return to IDLE, no pulses, and `o_Rx_Data` unchanged.
- **Framing error and recovery:** send 0x3C with the stop bit held low, then hold the line low for 2 bit times, then send 0x81. Expect:
  - one `o_Rx_FrameErr` pulse and `o_Rx_Data` unchanged;
  - the block stays in WAIT_IDLE until the line goes high;
  - then `o_Rx_Valid` with 0x81.
- **Back-to-back bytes:** send 0x00, 0xFF and 0x55 with no idle gap. Expect three `o_Rx_Valid` pulses with the data in order.
- **Reset mid-frame:** assert `reset_n` = 0 during data bit 4 of 0x96, then release it and send 0x12. Expect:
  - all outputs 0 during reset;
  - no pulse for the aborted frame;
  - `o_Rx_Valid` with 0x12.
- **Parity (with `UART_RX_PARITY_EN`):**
  - Send 0x07 with parity = 1: expect `o_Rx_Valid`.
  - Send 0x07 with parity = 0: expect `o_Rx_ParityErr`, no valid pulse, and `o_Rx_Data` = 0x07.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// Signal bundle between the UART receiver and the rest of the fabric.
// Handshake: the receiver side has valid-only semantics -- o_Rx_Valid,
// o_Rx_FrameErr and o_Rx_ParityErr are single-clk pulses with no ready/backpressure,
// so the consumer must capture o_Rx_Data in the cycle the pulse is high.
interface uart_rx_deserializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_ClkTick;
    logic                 i_Rx_Serial;
    logic [DATA_BITS-1:0] o_Rx_Data;
    logic                 o_Rx_Valid;
    logic                 o_Rx_FrameErr;
    logic                 o_Rx_ParityErr;
    logic                 o_Rx_Busy;
    logic [2:0]           dbg_state;

    // Receiver side: consumes the line and tick, produces bytes and status.
    modport master (
        input  i_Rx_ClkTick,
        input  i_Rx_Serial,
        output o_Rx_Data,
        output o_Rx_Valid,
        output o_Rx_FrameErr,
        output o_Rx_ParityErr,
        output o_Rx_Busy,
        output dbg_state
    );

    // Consumer / stimulus side.
    modport slave (
        output i_Rx_ClkTick,
        output i_Rx_Serial,
        input  o_Rx_Data,
        input  o_Rx_Valid,
        input  o_Rx_FrameErr,
        input  o_Rx_ParityErr,
        input  o_Rx_Busy,
        input  dbg_state
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 16x (OVERSAMPLE) oversampled, mid-bit sampling, start-glitch
// rejection, framing error detection. Optional even parity bit enabled by
// defining UART_RX_PARITY_EN; without it the frame is plain 8N1 and
// o_Rx_ParityErr is tied low.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_rx_deserializer_if.master rx
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY    = 3'd3;
`endif
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 tick_d1;
    logic                 tick_d2;
    logic                 s_tick;
    logic [2:0]           state;
    logic [CW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q;
    logic                 par_flag;
`endif

    // Two-flop synchronizer for the asynchronous RX pin; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx.i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    // Register the oversample square wave so its rising edge becomes a 1-clk strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_d1 <= 1'b0;
            tick_d2 <= 1'b0;
        end else begin
            tick_d1 <= rx.i_Rx_ClkTick;
            tick_d2 <= tick_d1;
        end
    end

    assign s_tick = tick_d1 & ~tick_d2;

    // Frame FSM: counters move only on s_tick; status pulses default low every clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            par_flag   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            if (s_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_sync) begin
                            state      <= ST_START;
                            sample_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (sample_cnt == CNT_MID) begin
                            sample_cnt <= '0;
                            bit_idx    <= '0;
                            // A start bit that is no longer low at mid-bit was noise.
                            state      <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            sample_cnt <= sample_cnt + CW'(1);
                        end
                    end
                    ST_DATA: begin
                        if (sample_cnt == CNT_LAST) begin
                            shift_reg  <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                            sample_cnt <= '0;
                            if (bit_idx == BIT_LAST) begin
                                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= ST_PARITY;
`else
                                state   <= ST_STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end else begin
                            sample_cnt <= sample_cnt + CW'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (sample_cnt == CNT_LAST) begin
                            // Even parity: data bits plus parity bit hold an even count of ones.
                            par_flag   <= rx_sync ^ (^shift_reg);
                            sample_cnt <= '0;
                            state      <= ST_STOP;
                        end else begin
                            sample_cnt <= sample_cnt + CW'(1);
                        end
                    end
`endif
                    ST_STOP: begin
                        if (sample_cnt == CNT_LAST) begin
                            sample_cnt <= '0;
                            if (rx_sync) begin
                                data_q <= shift_reg;
`ifdef UART_RX_PARITY_EN
                                if (par_flag) begin
                                    perr_q <= 1'b1;
                                end else begin
                                    valid_q <= 1'b1;
                                end
`else
                                valid_q <= 1'b1;
`endif
                                state <= ST_IDLE;
                            end else begin
                                ferr_q <= 1'b1;
                                state  <= ST_WAIT_IDLE;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + CW'(1);
                        end
                    end
                    ST_WAIT_IDLE: begin
                        // Break or stuck-low line: resume only once the line is back high.
                        if (rx_sync) begin
                            state      <= ST_IDLE;
                            sample_cnt <= '0;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        sample_cnt <= '0;
                        bit_idx    <= '0;
                    end
                endcase
            end
        end
    end

    assign rx.o_Rx_Data     = data_q;
    assign rx.o_Rx_Valid    = valid_q;
    assign rx.o_Rx_FrameErr = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx.o_Rx_ParityErr = perr_q;
`else
    assign rx.o_Rx_ParityErr = 1'b0;
`endif
    assign rx.o_Rx_Busy     = (state != ST_IDLE);
    assign rx.dbg_state     = state;

endmodule
